accelerator: RTL and testbench
==============================

ACCELERATOR -- requirements
Module: accelerator

Interface
REQ-001 Parameter NUM_SIZE, default 16: data word width in bits.
REQ-002 Parameter BUFFER_LEN, default 32: depth of both the instruction buffer and the data memory; must be a power of two.
REQ-003 Parameter GRID_SIZE, default 2: side N of the square N×N matrix operand.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have no other ports; benches load and observe it hierarchically.
REQ-007 Internal array `instructions[0:BUFFER_LEN-1]`, 24 bits wide, SHALL be hierarchically writable.
REQ-008 Internal array `memory[0:BUFFER_LEN-1]`, NUM_SIZE bits wide, SHALL be hierarchically writable and readable.
REQ-009 Internal registers SHALL be exposed hierarchically: `pc` (log2(BUFFER_LEN) bits) and `halted` (1 bit).

Function
REQ-010 Instruction fields: [23:18] opcode, [17:13] src A address, [12:8] src B address, [7:3] dest address, [2:0] reserved (ignored).
REQ-011 Opcodes: 0 NOP; 1 MATMUL; 10 HALT; every other value executes as NOP.
REQ-012 Matrices are stored row-major in N*N consecutive memory words starting at the given address; element (r,c) is at base + r*N + c.
REQ-013 MATMUL SHALL compute D = A × B, with D(r,c) = sum over k of A(r,k)*B(k,c).
REQ-014 Products and sums SHALL be unsigned and truncated to NUM_SIZE bits (modulo 2^NUM_SIZE).
REQ-015 Memory address arithmetic (base + offset) SHALL wrap modulo BUFFER_LEN.
REQ-016 State machine states: FETCH, LOAD, COMPUTE, STORE, HALT.
REQ-017 FETCH lasts 1 cycle: it decodes instructions[pc]. NOP/unknown -> pc+1, stay in FETCH. MATMUL -> LOAD. HALT -> HALT with halted=1.
REQ-018 LOAD lasts N*N cycles: each cycle copies one element of A and one of B into internal operand registers, in index order 0..N*N-1.
REQ-019 COMPUTE lasts N cycles: cycle k adds A(r,k)*B(k,c) into all N*N accumulators in parallel; accumulators are cleared on entry.
REQ-020 STORE lasts N*N cycles: each cycle writes one result word to memory[dest+i], i ascending; the final cycle increments pc and returns to FETCH.
REQ-021 MATMUL total latency SHALL be 1+2*N*N+N cycles from FETCH to the next FETCH (11 for N=2); a NOP takes 1 cycle.
REQ-022 Because all operands are loaded before any store, dest overlapping A or B SHALL still produce the product of the original operands.
REQ-023 pc SHALL wrap from BUFFER_LEN-1 to 0.
REQ-024 In HALT, pc, memory and halted SHALL hold until reset.
REQ-025 The instruction buffer SHALL never be written by the module.

Reset
REQ-026 When rst is high at a rising edge: pc=0, state=FETCH, halted=0, accumulators and operand registers=0.
REQ-027 Reset SHALL NOT clear `instructions` or `memory`.
REQ-028 Reset asserted mid-MATMUL SHALL abort the operation; result words already stored remain in memory.
REQ-029 Power-up initial values SHALL equal the reset values: pc=0, FETCH, halted=0, and both arrays all zero.

Verification
REQ-030 MATMUL reference test. Setup: memory[0..3]={3,1,4,1}, memory[4..7]={2,1,7,8}; instructions[4]={op 1, A 0, B 4, dest 8, 0}; instructions[7]={op 10}; all other instructions 0. Required: memory[8..11]={13,11,15,12}, halted=1, pc=7, within 30 cycles.
REQ-031 Latency test, same program: halted rises exactly 4+11+2+1 = 18 cycles after the first clock edge.
REQ-032 Overflow test: A and B elements all 16'hFFFF. Required: every result word = 16'h0002.
REQ-033 Aliasing test: dest = A base. Required: result equals the product of the original A and B.
REQ-034 Reset test: pulse rst during STORE. Required: pc=0, halted=0, and the program reruns to the correct result.
REQ-035 Wrap test: an all-NOP program (no HALT). Required: pc wraps 31 -> 0 and never halts.

Source files
------------

// File: rtl/accelerator.sv
// Self-contained NxN matrix-multiply engine with its own instruction buffer and data memory.
// A small FSM fetches 24-bit instructions and runs MATMUL as LOAD -> COMPUTE -> STORE.
module accelerator #(
    parameter int NUM_SIZE   = 16,
    parameter int BUFFER_LEN = 32,
    parameter int GRID_SIZE  = 2
) (
    input logic clk,
    input logic rst
);

    localparam int AW = (BUFFER_LEN > 1) ? $clog2(BUFFER_LEN) : 1;
    localparam int NN = GRID_SIZE * GRID_SIZE;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [5:0] OP_MATMUL = 6'd1;
    localparam logic [5:0] OP_HALT   = 6'd10;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        STORE   = 3'd3,
        HALT    = 3'd4
    } state_t;

    logic [23:0]         instructions [0:BUFFER_LEN-1] = '{default: 24'd0};
    logic [NUM_SIZE-1:0] memory       [0:BUFFER_LEN-1] = '{default: '0};

    state_t          state_q = FETCH;
    state_t          state_d;
    logic [AW-1:0]   pc      = '0;
    logic [AW-1:0]   pc_d;
    logic            halted  = 1'b0;
    logic            halted_d;
    logic [IW-1:0]   cnt_q   = '0;
    logic [IW-1:0]   cnt_d;

    logic [4:0] a_base_q = 5'd0;
    logic [4:0] b_base_q = 5'd0;
    logic [4:0] d_base_q = 5'd0;

    logic [NUM_SIZE-1:0] a_q   [0:NN-1] = '{default: '0};
    logic [NUM_SIZE-1:0] b_q   [0:NN-1] = '{default: '0};
    logic [NUM_SIZE-1:0] acc_q [0:NN-1] = '{default: '0};

    logic [5:0] opcode_s;
    logic       load_last_s;

    assign opcode_s    = instructions[pc][23:18];
    assign load_last_s = (cnt_q == IW'(NN - 1));

    // Base addresses are 5-bit fields; the sum wraps to the buffer size.
    function automatic logic [AW-1:0] addr_f(input logic [4:0] base, input logic [IW-1:0] off);
        logic [31:0] sum;
        sum = 32'(base) + 32'(off);
        return sum[AW-1:0];
    endfunction

    // Next-state, program counter and halt flag.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc;
        halted_d = halted;
        cnt_d    = cnt_q;
        case (state_q)
            FETCH: begin
                cnt_d = '0;
                if (opcode_s == OP_MATMUL) begin
                    state_d = LOAD;
                end else if (opcode_s == OP_HALT) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc + AW'(1);
                end
            end
            LOAD: begin
                if (load_last_s) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            COMPUTE: begin
                if (cnt_q == IW'(GRID_SIZE - 1)) begin
                    state_d = STORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            STORE: begin
                if (load_last_s) begin
                    state_d = FETCH;
                    pc_d    = pc + AW'(1);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc      <= '0;
            halted  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            halted  <= halted_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture and accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_base_q <= 5'd0;
            b_base_q <= 5'd0;
            d_base_q <= 5'd0;
            for (int i = 0; i < NN; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (opcode_s == OP_MATMUL) begin
                        a_base_q <= instructions[pc][17:13];
                        b_base_q <= instructions[pc][12:8];
                        d_base_q <= instructions[pc][7:3];
                    end
                end
                LOAD: begin
                    a_q[cnt_q] <= memory[addr_f(a_base_q, cnt_q)];
                    b_q[cnt_q] <= memory[addr_f(b_base_q, cnt_q)];
                    if (load_last_s) begin
                        for (int i = 0; i < NN; i++) begin
                            acc_q[i] <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    // All N*N dot products advance by one k term per cycle.
                    for (int r = 0; r < GRID_SIZE; r++) begin
                        for (int c = 0; c < GRID_SIZE; c++) begin
                            acc_q[r*GRID_SIZE + c] <= acc_q[r*GRID_SIZE + c]
                                + a_q[r*GRID_SIZE + int'(cnt_q)] * b_q[int'(cnt_q)*GRID_SIZE + c];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result write-back; plain always so the array stays writable from outside.
    always @(posedge clk) begin
        if (!rst && state_q == STORE) begin
            memory[addr_f(d_base_q, cnt_q)] <= acc_q[cnt_q];
        end
    end

endmodule

// File: tb/tb_accelerator.sv
// Directed self-checking bench for accelerator: programs and data are loaded hierarchically.
module tb_accelerator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    accelerator #(.NUM_SIZE(16), .BUFFER_LEN(32), .GRID_SIZE(2)) dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d);
        return {op, a, b, d, 3'd0};
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 32; i++) begin
            dut.instructions[i] = 24'd0;
            dut.memory[i]       = 16'd0;
        end
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int max, output int cycles);
        cycles = 0;
        while (dut.halted !== 1'b1 && cycles < max) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic load_reference();
        logic [15:0] a_v [4] = '{16'd3, 16'd1, 16'd4, 16'd1};
        logic [15:0] b_v [4] = '{16'd2, 16'd1, 16'd7, 16'd8};
        clear_all();
        for (int i = 0; i < 4; i++) begin
            dut.memory[i]     = a_v[i];
            dut.memory[4 + i] = b_v[i];
        end
        dut.instructions[4] = mk(6'd1, 5'd0, 5'd4, 5'd8);
        dut.instructions[7] = mk(6'd10, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        hold_reset();
        clear_all();
        dut.memory[3] = 16'h0055;
        hold_reset();
        checks++;
        if (dut.pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", dut.pc); end
        checks++;
        if (dut.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", dut.halted); end
        checks++;
        if (dut.acc_q[0] !== 16'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", dut.acc_q[0]); end
        checks++;
        if (dut.memory[3] !== 16'h0055) begin failures++; $display("FAIL reset_keeps_mem got=%h exp=0055", dut.memory[3]); end
    endtask

    task automatic test_matmul();
        logic [15:0] exp_v [4] = '{16'd13, 16'd11, 16'd15, 16'd12};
        int cyc;
        hold_reset();
        load_reference();
        rst = 1'b0;
        run(30, cyc);
        checks++;
        if (dut.halted !== 1'b1) begin failures++; $display("FAIL matmul_halted got=%b exp=1", dut.halted); end
        checks++;
        if (cyc !== 18) begin failures++; $display("FAIL matmul_latency got=%0d exp=18", cyc); end
        checks++;
        if (dut.pc !== 5'd7) begin failures++; $display("FAIL matmul_pc got=%0d exp=7", dut.pc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.memory[8 + i] !== exp_v[i]) begin
                failures++; $display("FAIL matmul_d%0d got=%0d exp=%0d", i, dut.memory[8 + i], exp_v[i]);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (dut.pc !== 5'd7 || dut.halted !== 1'b1) begin
            failures++; $display("FAIL halt_hold pc=%0d halted=%b exp pc=7 halted=1", dut.pc, dut.halted);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        hold_reset();
        clear_all();
        for (int i = 0; i < 8; i++) dut.memory[i] = 16'hFFFF;
        dut.instructions[0] = mk(6'd1, 5'd0, 5'd4, 5'd8);
        dut.instructions[1] = mk(6'd10, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        run(30, cyc);
        checks++;
        if (cyc !== 12) begin failures++; $display("FAIL overflow_latency got=%0d exp=12", cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.memory[8 + i] !== 16'h0002) begin
                failures++; $display("FAIL overflow_d%0d got=%h exp=0002", i, dut.memory[8 + i]);
            end
        end
    endtask

    task automatic test_alias();
        logic [15:0] exp_v [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        int cyc;
        hold_reset();
        clear_all();
        for (int i = 0; i < 4; i++) begin
            dut.memory[i]     = 16'(i + 1);
            dut.memory[4 + i] = 16'(i + 5);
        end
        dut.instructions[0] = mk(6'd1, 5'd0, 5'd4, 5'd0);
        dut.instructions[1] = mk(6'd10, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        run(30, cyc);
        checks++;
        if (dut.halted !== 1'b1) begin failures++; $display("FAIL alias_halted got=%b exp=1", dut.halted); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.memory[i] !== exp_v[i]) begin
                failures++; $display("FAIL alias_d%0d got=%0d exp=%0d", i, dut.memory[i], exp_v[i]);
            end
        end
        checks++;
        if (dut.memory[7] !== 16'd8) begin failures++; $display("FAIL alias_b_kept got=%0d exp=8", dut.memory[7]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp1 [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        logic [15:0] exp2 [4] = '{16'd7, 16'd10, 16'd15, 16'd22};
        int cyc;
        hold_reset();
        clear_all();
        dut.memory[30] = 16'd1;
        dut.memory[31] = 16'd2;
        dut.memory[0]  = 16'd3;
        dut.memory[1]  = 16'd4;
        dut.memory[4]  = 16'd1;
        dut.memory[7]  = 16'd1;
        dut.instructions[0] = mk(6'd1, 5'd30, 5'd4, 5'd8);
        dut.instructions[1] = mk(6'd1, 5'd8, 5'd8, 5'd12);
        dut.instructions[2] = mk(6'd5, 5'd1, 5'd2, 5'd20);
        dut.instructions[3] = mk(6'd10, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;
        run(40, cyc);
        checks++;
        if (cyc !== 24) begin failures++; $display("FAIL b2b_latency got=%0d exp=24", cyc); end
        checks++;
        if (dut.pc !== 5'd3) begin failures++; $display("FAIL b2b_pc got=%0d exp=3", dut.pc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.memory[8 + i] !== exp1[i]) begin
                failures++; $display("FAIL b2b_wrap_d%0d got=%0d exp=%0d", i, dut.memory[8 + i], exp1[i]);
            end
            checks++;
            if (dut.memory[12 + i] !== exp2[i]) begin
                failures++; $display("FAIL b2b_sq_d%0d got=%0d exp=%0d", i, dut.memory[12 + i], exp2[i]);
            end
        end
        checks++;
        if (dut.memory[20] !== 16'd0) begin failures++; $display("FAIL unknown_op_nowrite got=%0d exp=0", dut.memory[20]); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_v [4] = '{16'd13, 16'd11, 16'd15, 16'd12};
        int cyc;
        hold_reset();
        load_reference();
        rst = 1'b0;
        repeat (13) @(negedge clk);
        checks++;
        if (dut.memory[9] !== 16'd11 || dut.memory[10] !== 16'd0) begin
            failures++; $display("FAIL mid_store m9=%0d m10=%0d exp 11 0", dut.memory[9], dut.memory[10]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.pc !== 5'd0 || dut.halted !== 1'b0) begin
            failures++; $display("FAIL mid_reset pc=%0d halted=%b exp pc=0 halted=0", dut.pc, dut.halted);
        end
        checks++;
        if (dut.memory[8] !== 16'd13 || dut.memory[10] !== 16'd0) begin
            failures++; $display("FAIL mid_abort m8=%0d m10=%0d exp 13 0", dut.memory[8], dut.memory[10]);
        end
        rst = 1'b0;
        run(30, cyc);
        checks++;
        if (cyc !== 18 || dut.pc !== 5'd7) begin
            failures++; $display("FAIL rerun cycles=%0d pc=%0d exp 18 7", cyc, dut.pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.memory[8 + i] !== exp_v[i]) begin
                failures++; $display("FAIL rerun_d%0d got=%0d exp=%0d", i, dut.memory[8 + i], exp_v[i]);
            end
        end
    endtask

    task automatic test_wrap();
        hold_reset();
        clear_all();
        rst = 1'b0;
        repeat (31) @(negedge clk);
        checks++;
        if (dut.pc !== 5'd31) begin failures++; $display("FAIL wrap_pc31 got=%0d exp=31", dut.pc); end
        @(negedge clk);
        checks++;
        if (dut.pc !== 5'd0) begin failures++; $display("FAIL wrap_pc0 got=%0d exp=0", dut.pc); end
        repeat (40) @(negedge clk);
        checks++;
        if (dut.pc !== 5'd8 || dut.halted !== 1'b0) begin
            failures++; $display("FAIL wrap_nohalt pc=%0d halted=%b exp pc=8 halted=0", dut.pc, dut.halted);
        end
    endtask

    initial begin
        test_reset();
        test_matmul();
        test_overflow();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
